// File: rtl/serializer_10b.sv
// 10-bit parallel-to-serial stage for 8b/10b code groups.
// Fills idle slots with K28.5 commas of matching running disparity.
module serializer_10b #(
    parameter bit         MSB_FIRST = 1'b0,
    parameter logic [9:0] COMMA_NEG = 10'h0FA,
    parameter logic [9:0] COMMA_POS = 10'h305
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic [9:0] dataIn,
    input  logic       valid,
    output logic       ready,
    output logic       serialOut,
    output logic       frameStart,
    output logic       rdOut,
    output logic       codeErr
);

    logic [9:0] sh_q, sh_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rd_q, rd_d;
    logic       err_q, err_d;
    logic [9:0] word;
    logic [3:0] ones;

    function automatic logic [3:0] popcount10(input logic [9:0] w);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 10; i++) begin
            c = c + {3'b000, w[i]};
        end
        return c;
    endfunction

    assign ready      = enb & ~rst & (cnt_q == 4'd9);
    assign serialOut  = MSB_FIRST ? sh_q[9] : sh_q[0];
    assign frameStart = (cnt_q == 4'd0) & ~rst;
    assign rdOut      = rd_q;
    assign codeErr    = err_q;

    always_comb begin
        word  = valid ? dataIn : (rd_q ? COMMA_POS : COMMA_NEG);
        ones  = popcount10(word);
        sh_d  = sh_q;
        cnt_d = cnt_q;
        rd_d  = rd_q;
        err_d = err_q;
        if (enb) begin
            if (cnt_q == 4'd9) begin
                sh_d  = word;
                cnt_d = 4'd0;
                // Weights 4 and 6 flip disparity; anything off-balance also flips it.
                if (ones != 4'd5) begin
                    rd_d = ~rd_q;
                end
                if (valid && ((ones < 4'd4) || (ones > 4'd6))) begin
                    err_d = 1'b1;
                end
            end else begin
                sh_d  = MSB_FIRST ? {sh_q[8:0], 1'b0} : {1'b0, sh_q[9:1]};
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= 10'd0;
            cnt_q <= 4'd9;
            rd_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            err_q <= err_d;
        end
    end

endmodule
